// File: rtl/note_recorder.sv
// note_recorder: slot-based note capture into a DEPTH-entry packed buffer, with one-shot/loop takes
module note_recorder #(
    parameter int NOTE_WIDTH   = 6,
    parameter int DEPTH        = 160,
    parameter int IDX_WIDTH    = 8,
    parameter int PERIOD_WIDTH = 26,
    parameter int REST_NOTE    = 0,
    parameter int HOLD_LAST    = 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        record_in,
    input  logic                        loop_in,
    input  logic [PERIOD_WIDTH-1:0]     period_in,
    input  logic [NOTE_WIDTH-1:0]       note_in,
    input  logic                        note_valid_in,
    output logic [DEPTH*NOTE_WIDTH-1:0] notes_out,
    output logic [IDX_WIDTH-1:0]        write_index_out,
    output logic                        recording_out,
    output logic                        full_out,
    output logic                        wrapped_out,
    output logic                        slot_strobe_out
);
    typedef enum logic [1:0] {IDLE, RECORD, DONE} state_t;
    localparam logic [NOTE_WIDTH-1:0] REST = NOTE_WIDTH'(REST_NOTE);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DEPTH - 1);
    state_t state_q, state_d;
    logic [DEPTH*NOTE_WIDTH-1:0] notes_q, notes_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [NOTE_WIDTH-1:0] cap_q, cap_d, wr_note;
    logic seen_q, seen_d, wrapped_q, wrapped_d, strobe_q, strobe_d, slot_end;

    always_comb begin
        state_d   = state_q;
        notes_d   = notes_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        cap_d     = cap_q;
        seen_d    = seen_q;
        wrapped_d = wrapped_q;
        strobe_d  = 1'b0;
        slot_end  = cnt_q == period_q - PERIOD_WIDTH'(1);
        wr_note   = note_valid_in ? note_in : (seen_q || HOLD_LAST != 0) ? cap_q : REST;
        case (state_q)
            IDLE: begin
                if (record_in) begin
                    state_d   = RECORD;
                    notes_d   = {DEPTH{REST}};
                    idx_d     = '0;
                    cnt_d     = '0;
                    wrapped_d = 1'b0;
                    seen_d    = 1'b0;
                    cap_d     = REST;
                    period_d  = (period_in == '0) ? PERIOD_WIDTH'(1) : period_in;
                end
            end
            RECORD: begin
                if (!record_in) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PERIOD_WIDTH'(1);
                    if (note_valid_in) begin
                        cap_d  = note_in;
                        seen_d = 1'b1;
                    end
                    // A note on the slot-end cycle belongs to the ending slot only
                    if (slot_end) begin
                        notes_d[int'(idx_q)*NOTE_WIDTH +: NOTE_WIDTH] = wr_note;
                        strobe_d = 1'b1;
                        cnt_d    = '0;
                        seen_d   = 1'b0;
                        if (idx_q != IDX_LAST) begin
                            idx_d = idx_q + IDX_WIDTH'(1);
                        end else if (loop_in) begin
                            idx_d     = '0;
                            wrapped_d = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: state_d = record_in ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            notes_q   <= {DEPTH{REST}};
            idx_q     <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            cap_q     <= '0;
            seen_q    <= 1'b0;
            wrapped_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            notes_q   <= notes_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            cap_q     <= cap_d;
            seen_q    <= seen_d;
            wrapped_q <= wrapped_d;
            strobe_q  <= strobe_d;
        end
    end

    assign notes_out       = notes_q;
    assign write_index_out = idx_q;
    assign recording_out   = state_q == RECORD;
    assign full_out        = state_q == DONE;
    assign wrapped_out     = wrapped_q;
    assign slot_strobe_out = strobe_q;
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: directed checks of note_recorder with DEPTH=4, HOLD_LAST=0 and a HOLD_LAST=1 twin
module tb_note_recorder;
    logic clk = 1'b0, rst = 1'b1, rec = 1'b0, lp = 1'b0, nv = 1'b0;
    logic [25:0] per = 26'd3;
    logic [5:0] note = 6'd0;
    logic [23:0] nz, nh;
    logic [1:0] iz, ih;
    logic rz, rh, fz, fh, wz, wh, sz, sh;
    int vectors = 0, errs = 0;

    always #5 clk = ~clk;

    note_recorder #(.NOTE_WIDTH(6), .DEPTH(4), .IDX_WIDTH(2), .PERIOD_WIDTH(26), .REST_NOTE(0), .HOLD_LAST(0)) dut (
        .clk_in(clk), .rst_in(rst), .record_in(rec), .loop_in(lp), .period_in(per), .note_in(note),
        .note_valid_in(nv), .notes_out(nz), .write_index_out(iz), .recording_out(rz), .full_out(fz),
        .wrapped_out(wz), .slot_strobe_out(sz));

    note_recorder #(.NOTE_WIDTH(6), .DEPTH(4), .IDX_WIDTH(2), .PERIOD_WIDTH(26), .REST_NOTE(0), .HOLD_LAST(1)) dut_h (
        .clk_in(clk), .rst_in(rst), .record_in(rec), .loop_in(lp), .period_in(per), .note_in(note),
        .note_valid_in(nv), .notes_out(nh), .write_index_out(ih), .recording_out(rh), .full_out(fh),
        .wrapped_out(wh), .slot_strobe_out(sh));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] sl(input logic [23:0] v, input int i);
        return v[i*6 +: 6];
    endfunction

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_notes", nz, 0);
        chk("rst_idx", iz, 0);
        chk("rst_rec", rz, 0);
        chk("rst_full", fz, 0);
        chk("rst_wrap", wz, 0);
        chk("rst_strobe", sz, 0);

        // one-shot, period 3, note 5 every cycle
        per = 26'd3; note = 6'd5; nv = 1'b1; rec = 1'b1;
        tick();
        chk("os_rec", rz, 1);
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("os_strobe%0d", c), sz, (c % 3) == 0);
        end
        chk("os_notes", nz, {6'd5, 6'd5, 6'd5, 6'd5});
        chk("os_full", fz, 1);
        chk("os_idx", iz, 3);
        repeat (4) tick();
        chk("done_hold_full", fz, 1);
        chk("done_hold_strobe", sz, 0);
        chk("done_hold_idx", iz, 3);
        chk("done_hold_rec", rz, 0);
        rec = 1'b0; nv = 1'b0;
        tick();
        chk("done_exit", fz, 0);

        // empty slot 1: REST vs hold-last
        rec = 1'b1;
        tick();
        note = 6'd9; nv = 1'b1;
        tick();
        nv = 1'b0;
        repeat (5) tick();
        rec = 1'b0;
        tick();
        chk("h0_s0", sl(nz, 0), 9);
        chk("h0_s1", sl(nz, 1), 0);
        chk("h0_s2", sl(nz, 2), 0);
        chk("h1_s0", sl(nh, 0), 9);
        chk("h1_s1", sl(nh, 1), 9);
        chk("h1_s2", sl(nh, 2), 0);
        chk("h0_idx", iz, 0);

        // loop, period 2, notes 1..6
        per = 26'd2; lp = 1'b1; rec = 1'b1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            note = 6'(k); nv = 1'b1;
            tick();
            nv = 1'b0;
            tick();
            if (k == 3) chk("lp_nowrap3", wz, 0);
            if (k == 4) begin
                chk("lp_wrap4", wz, 1);
                chk("lp_idx4", iz, 0);
            end
        end
        chk("lp_notes", nz, {6'd4, 6'd3, 6'd6, 6'd5});
        chk("lp_wrap", wz, 1);
        chk("lp_idx", iz, 2);
        chk("lp_full", fz, 0);
        rec = 1'b0; lp = 1'b0;
        tick();

        // note on slot-end cycle wins over earlier note
        per = 26'd3; rec = 1'b1;
        tick();
        note = 6'd8; nv = 1'b1;
        tick();
        nv = 1'b0;
        tick();
        note = 6'd7; nv = 1'b1;
        tick();
        chk("se_strobe", sz, 1);
        nv = 1'b0;
        repeat (3) tick();
        chk("se_s0", sl(nz, 0), 7);
        chk("se_s1", sl(nz, 1), 0);
        chk("se_h_s1", sl(nh, 1), 7);
        rec = 1'b0;
        tick();

        // abort after two writes, abort beats slot end
        per = 26'd2; note = 6'd3; nv = 1'b1; rec = 1'b1;
        tick();
        repeat (5) tick();
        rec = 1'b0;
        tick();
        chk("ab_strobe", sz, 0);
        chk("ab_rec", rz, 0);
        chk("ab_idx", iz, 0);
        chk("ab_notes", nz, {6'd0, 6'd0, 6'd3, 6'd3});
        rec = 1'b1;
        tick();
        chk("ab_clear", nz, 0);
        chk("ab_rerec", rz, 1);
        rec = 1'b0;
        tick();

        // period 0 acts as period 1, then reset mid-take
        per = 26'd0; note = 6'd11; rec = 1'b1;
        tick();
        tick();
        chk("p0_strobe1", sz, 1);
        chk("p0_idx1", iz, 1);
        tick();
        chk("p0_strobe2", sz, 1);
        chk("p0_idx2", iz, 2);
        chk("p0_notes", nz, {6'd0, 6'd0, 6'd11, 6'd11});
        rst = 1'b1;
        tick();
        chk("mr_notes", nz, 0);
        chk("mr_idx", iz, 0);
        chk("mr_rec", rz, 0);
        chk("mr_strobe", sz, 0);
        chk("mr_wrap", wz, 0);
        chk("mr_full", fz, 0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
